decode_cycle: RTL
=================

Name: decode_cycle

Overview:
- ID stage of the 5-stage RV64 pipeline. Sits directly downstream of the fetch stage and consumes its InstrD/PCD/PCPlus4D.
- Contains:
  - 32x64 register file, written back from the W stage.
  - Main/ALU control decode.
  - Immediate sign-extension.
  - ID/EX pipeline register feeding the execute stage.
- Branch-taken flush input turns the EX-bound slot into a bubble.

Parameters:
- XLEN, 64, datapath / register width
- NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
- clk input 1 pipeline clock, all state on rising edge
- rst input 1 asynchronous active-low reset
- InstrD input 32 instruction from fetch stage register
- PCD input 64 PC of InstrD
- PCPlus4D input 64 PC+4 of InstrD
- RegWriteW input 1 writeback enable
- RDW input 5 writeback destination register
- ResultW input 64 writeback data
- FlushE input 1 squash the instruction entering EX (driven by PCSrcE)
- RegWriteE output 1 EX-stage register write enable
- ResultSrcE output 1 0=ALU result, 1=memory data
- MemWriteE output 1 store enable
- BranchE output 1 instruction is beq
- ALUSrcE output 1 0=RD2, 1=immediate
- ALUControlE output 3 000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E output 64 rs1 value
- RD2E output 64 rs2 value
- ImmExtE output 64 sign-extended immediate
- RS1E output 5 rs1 index (for hazard unit)
- RS2E output 5 rs2 index
- RDE output 5 rd index
- PCE output 64 registered PCD
- PCPlus4E output 64 registered PCPlus4D

Behaviour:
**Reset**
- rst low asynchronously clears all 32 registers and every ID/EX output to 0.
- While rst is low, all outputs are forced to 0.

**Register file**
- Written on posedge clk when RegWriteW=1 and RDW!=0. Writes with RDW=0 are ignored.
- Reads are combinational on InstrD[19:15] and InstrD[24:20]; x0 always reads 0.
- Write-through bypass: if RegWriteW=1, RDW!=0 and RDW equals a read index, that read returns ResultW in the same cycle.

**Decode (opcode InstrD[6:0])**
- 0110011 R-type: RegWrite=1, ALUSrc=0.
  - funct3 000 & funct7[5]=0 -> add; funct7[5]=1 -> sub.
  - funct3 111 -> and; 110 -> or; 010 -> slt.
- 0010011 I-ALU: RegWrite=1, ALUSrc=1, I-imm.
  - funct3 000 -> add; 111 -> and; 110 -> or; 010 -> slt.
- 0000011 ld (funct3 011): RegWrite=1, ResultSrc=1, ALUSrc=1, add, I-imm.
- 0100011 sd (funct3 011): MemWrite=1, ALUSrc=1, add, S-imm.
- 1100011 beq (funct3 000): Branch=1, ALUSrc=0, sub, B-imm.
- Any other opcode or funct3: all control bits 0 (bubble). Data fields are still registered.

**Immediates (sign-extended from bit 31 to 64)**
- I: imm[11:0] = Instr[31:20].
- S: imm[11:0] = {Instr[31:25], Instr[11:7]}.
- B: imm[12:0] = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
- Otherwise 0.

**ID/EX register**
- Latency: 1 cycle. Values decoded in cycle N appear on the E outputs after posedge N+1.
- FlushE=1 at the edge: all E outputs load 0 (NOP bubble).
- FlushE has priority over new data.
- A flush and a register write in the same cycle both take effect.

**Reset mid-operation**
- Pipeline contents are lost and registers are cleared.
- Decode resumes on the first edge after rst rises.

Test Plan:
- Reset: rst=0 with InstrD=0x002081B3 -> every output 0; after release, x1..x31 read 0.
- addi x1,x0,5 (0x00500093) -> next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=5, RDE=1, RD1E=0.
- Bypass: RegWriteW=1, RDW=1, ResultW=0x1234 while InstrD=add x3,x1,x2 (0x002081B3) -> RD1E=0x1234 at next edge. A write with RDW=0 is ignored and x0 still reads 0.
- sub (0x402081B3) -> ALUControlE=001.
- sd x2,-8(x1) (0xFE20BC23) -> MemWriteE=1, RegWriteE=0, ImmExtE=0xFFFFFFFFFFFFFFF8.
- beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=-8.
- FlushE=1 with a valid addi -> all E outputs 0 next cycle.
- Unknown opcode 0x0000007F -> all control bits 0.
- Reset pulse mid-stream -> outputs clear asynchronously.

Source files
------------

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle : ID stage of the 5-stage RV64 pipeline.
//
// Register file (x0 hardwired to zero, written back from W with a
// write-through bypass), main/ALU control decode, immediate
// sign-extension and the ID/EX pipeline register.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   InstrD/PCD/PCPlus4D instruction and its PCs from the fetch register
//   RegWriteW/RDW/ResultW  writeback port
//   FlushE              turn the slot entering EX into a bubble
//   *E outputs          registered control and data for the execute stage
// ---------------------------------------------------------------------------
module decode_cycle #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            ResultSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_ctl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t           ctl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } idex_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf [NREGS];
    logic            wb_en;
    logic [XLEN-1:0] rd1, rd2;

    // Writes to x0 are dropped here so x0 can never hold a nonzero value.
    assign wb_en = RegWriteW && (RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[RDW] <= ResultW;
        end
    end

    // Write-through: a same-cycle W write to a source register wins over
    // the stale array contents, so no separate WB->ID forwarding is needed.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) rd1 = (wb_en && RDW == rs1) ? ResultW : rf[rs1];
        if (rs2 != 5'd0) rd2 = (wb_en && RDW == rs2) ? ResultW : rf[rs2];
    end

    // ---------------- control decode ----------------
    ctrl_t ctl;

    always_comb begin
        ctl = '0;
        case (opcode)
            OP_R: begin
                ctl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  ctl.alu_ctl = InstrD[30] ? ALU_SUB : ALU_ADD;
                    3'b111:  ctl.alu_ctl = ALU_AND;
                    3'b110:  ctl.alu_ctl = ALU_OR;
                    3'b010:  ctl.alu_ctl = ALU_SLT;
                    default: ctl = '0;
                endcase
            end
            OP_I: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                case (funct3)
                    3'b000:  ctl.alu_ctl = ALU_ADD;
                    3'b111:  ctl.alu_ctl = ALU_AND;
                    3'b110:  ctl.alu_ctl = ALU_OR;
                    3'b010:  ctl.alu_ctl = ALU_SLT;
                    default: ctl = '0;
                endcase
            end
            OP_LD: if (funct3 == 3'b011) begin
                ctl.reg_write  = 1'b1;
                ctl.result_src = 1'b1;
                ctl.alu_src    = 1'b1;
                ctl.alu_ctl    = ALU_ADD;
            end
            OP_SD: if (funct3 == 3'b011) begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_ctl   = ALU_ADD;
            end
            OP_BEQ: if (funct3 == 3'b000) begin
                ctl.branch  = 1'b1;
                ctl.alu_ctl = ALU_SUB;
            end
            default: ctl = '0;
        endcase
    end

    // ---------------- immediate ----------------
    // Format is chosen by opcode only; an unsupported funct3 still carries
    // its immediate through as data, just with all control bits cleared.
    logic [XLEN-1:0] imm;

    always_comb begin
        imm = '0;
        case (opcode)
            OP_I, OP_LD: imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            OP_SD:       imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            OP_BEQ:      imm = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                                InstrD[30:25], InstrD[11:8], 1'b0};
            default:     imm = '0;
        endcase
    end

    // ---------------- ID/EX register ----------------
    idex_t idex_d, idex_q;

    always_comb begin
        idex_d     = '0;
        idex_d.ctl = ctl;
        idex_d.rd1 = rd1;
        idex_d.rd2 = rd2;
        idex_d.imm = imm;
        idex_d.rs1 = rs1;
        idex_d.rs2 = rs2;
        idex_d.rd  = InstrD[11:7];
        idex_d.pc  = PCD;
        idex_d.pc4 = PCPlus4D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        idex_q <= '0;
        else if (FlushE) idex_q <= '0;
        else             idex_q <= idex_d;
    end

    assign RegWriteE   = idex_q.ctl.reg_write;
    assign ResultSrcE  = idex_q.ctl.result_src;
    assign MemWriteE   = idex_q.ctl.mem_write;
    assign BranchE     = idex_q.ctl.branch;
    assign ALUSrcE     = idex_q.ctl.alu_src;
    assign ALUControlE = idex_q.ctl.alu_ctl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign RS1E        = idex_q.rs1;
    assign RS2E        = idex_q.rs2;
    assign RDE         = idex_q.rd;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;

endmodule
